hdlverifier_reg_bank: RTL and testbench

HDLVERIFIER_REG_BANK -- requirements
Module: hdlverifier_reg_bank

---
 rtl/hdlverifier_pkg.sv | 13 +
 rtl/hdlverifier_capture_bank.sv | 51 +++++
 rtl/hdlverifier_reg_bank.sv | 183 ++++++++++++++++++
 tb/tb_hdlverifier_reg_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_pkg.sv
// Shared FSM encoding and address constants for the hdlverifier register bank.
package hdlverifier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // SNAP control sits this far below the top of the address space.
    localparam int unsigned SNAP_OFFSET = 1;

endpackage

// File: rtl/hdlverifier_capture_bank.sv
// Per-cycle sample of the user inputs, plus optional shadow copy and capture
// counter when HDLV_REG_BANK_SNAPSHOT_EN is defined.
module hdlverifier_capture_bank
    import hdlverifier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_IN     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_i,
    output logic [NUM_IN*DATA_WIDTH-1:0] view_o
`ifdef HDLV_REG_BANK_SNAPSHOT_EN
    ,
    input  logic                         snap_i,
    output logic [DATA_WIDTH-1:0]        count_o
`endif
);

    logic [NUM_IN*DATA_WIDTH-1:0] sample_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_q <= '0;
        end else begin
            sample_q <= data_i;
        end
    end

`ifdef HDLV_REG_BANK_SNAPSHOT_EN
    logic [NUM_IN*DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0]        count_q;

    // All channels freeze together on a single edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q <= '0;
            count_q  <= '0;
        end else if (snap_i) begin
            shadow_q <= sample_q;
            count_q  <= count_q + DATA_WIDTH'(1);
        end
    end

    assign view_o  = shadow_q;
    assign count_o = count_q;
`else
    assign view_o = sample_q;
`endif

endmodule

// File: rtl/hdlverifier_reg_bank.sv
// Host-accessed register bank: NUM_OUT writable outputs, NUM_IN readable inputs.
// Optional SNAP shadow/counter feature under HDLV_REG_BANK_SNAPSHOT_EN.
module hdlverifier_reg_bank
    import hdlverifier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  user_data_in,
    output logic [NUM_OUT*DATA_WIDTH-1:0] user_data_out,
    output logic [NUM_OUT-1:0]            user_wr_strobe
);

    if ((NUM_OUT < 1) || (NUM_OUT > 16)) begin : g_bad_num_out
        $error("hdlverifier_reg_bank: NUM_OUT must be 1..16");
    end
    if ((NUM_IN < 1) || (NUM_IN > 16)) begin : g_bad_num_in
        $error("hdlverifier_reg_bank: NUM_IN must be 1..16");
    end
    if ((NUM_OUT + NUM_IN + 1) > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
        $error("hdlverifier_reg_bank: ADDR_WIDTH too small for register map");
    end

    state_e                  state_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic [NUM_OUT-1:0]      sel_out;
    logic [NUM_IN-1:0]       sel_in;
    logic [DATA_WIDTH-1:0]   out_acc [NUM_OUT+1];
    logic [DATA_WIDTH-1:0]   in_acc  [NUM_IN+1];
    logic [NUM_IN*DATA_WIDTH-1:0] in_view;
    logic                    is_snap;
    logic [DATA_WIDTH-1:0]   snap_term;
    logic                    wr_en_c;
    logic                    err_c;
    logic [DATA_WIDTH-1:0]   rdata_c;

    assign wr_en_c = (state_q == ST_ACCESS) && wr_q;

`ifdef HDLV_REG_BANK_SNAPSHOT_EN
    localparam logic [ADDR_WIDTH-1:0] SNAP_ADDR =
        ADDR_WIDTH'((1 << ADDR_WIDTH) - SNAP_OFFSET);
    logic [DATA_WIDTH-1:0] snap_count;

    assign is_snap   = (addr_q == SNAP_ADDR);
    assign snap_term = is_snap ? snap_count : '0;

    hdlverifier_capture_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_IN)
    ) u_capture (
        .clk     (clk),
        .reset_n (reset_n),
        .data_i  (user_data_in),
        .view_o  (in_view),
        .snap_i  (wr_en_c && is_snap),
        .count_o (snap_count)
    );
`else
    assign is_snap   = 1'b0;
    assign snap_term = '0;

    hdlverifier_capture_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_IN)
    ) u_capture (
        .clk     (clk),
        .reset_n (reset_n),
        .data_i  (user_data_in),
        .view_o  (in_view)
    );
`endif

    assign out_acc[0] = '0;
    assign in_acc[0]  = '0;

    // Output channels: decode, register, strobe and read-mux contribution.
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        logic [DATA_WIDTH-1:0] chan_q;
        logic                  strb_q;

        assign sel_out[k] = (addr_q == ADDR_WIDTH'(k));

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                chan_q <= '0;
                strb_q <= 1'b0;
            end else begin
                strb_q <= 1'b0;
                if (wr_en_c && sel_out[k]) begin
                    chan_q <= wdata_q;
                    strb_q <= 1'b1;
                end
            end
        end

        assign out_acc[k+1] = out_acc[k] | (sel_out[k] ? chan_q : '0);
        assign user_data_out[k*DATA_WIDTH +: DATA_WIDTH] = chan_q;
        assign user_wr_strobe[k] = strb_q;
    end

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        assign sel_in[k]   = (addr_q == ADDR_WIDTH'(NUM_OUT + k));
        assign in_acc[k+1] = in_acc[k] |
                             (sel_in[k] ? in_view[k*DATA_WIDTH +: DATA_WIDTH] : '0);
    end

    // Writes may only target output registers or SNAP; reads also reach inputs.
    assign err_c   = wr_q ? !((|sel_out) || is_snap)
                          : !((|sel_out) || (|sel_in) || is_snap);
    assign rdata_c = (wr_q || err_c) ? '0
                   : (out_acc[NUM_OUT] | in_acc[NUM_IN] | snap_term);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_c;
                    rsp_rdata_q <= rdata_c;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_hdlverifier_reg_bank.sv
// Directed scoreboard bench for hdlverifier_reg_bank (default parameters).
module tb_hdlverifier_reg_bank;

    localparam int DW = 32;
    localparam int NO = 4;
    localparam int NI = 4;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [AW-1:0]      req_addr;
    logic [DW-1:0]      req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic [NI*DW-1:0]   user_data_in;
    logic [NO*DW-1:0]   user_data_out;
    logic [NO-1:0]      user_wr_strobe;

    hdlverifier_reg_bank #(
        .DATA_WIDTH (DW),
        .NUM_OUT    (NO),
        .NUM_IN     (NI),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .user_data_in   (user_data_in),
        .user_data_out  (user_data_out),
        .user_wr_strobe (user_wr_strobe)
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic [NO-1:0] strb;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] out_m [NO];
    logic [DW-1:0] in_m  [NI];
    logic [DW-1:0] sh_m  [NI];
    logic [DW-1:0] cnt_m;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [NO*DW-1:0] obs,
                       input logic [NO*DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NO*DW-1:0] out_packed();
        logic [NO*DW-1:0] v;
        for (int i = 0; i < NO; i++) v[i*DW +: DW] = out_m[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NO; i++) out_m[i] = '0;
        for (int i = 0; i < NI; i++) sh_m[i] = '0;
        cnt_m = '0;
    endtask

    task automatic set_in(input int ch, input logic [DW-1:0] v);
        in_m[ch] = v;
        user_data_in[ch*DW +: DW] = v;
    endtask

    // Reference behaviour of one request, applied to the model state.
    task automatic model(input bit wr, input int a, input logic [DW-1:0] wd,
                         output exp_t e);
        e = '0;
        if (a < NO) begin
            if (wr) begin
                out_m[a] = wd;
                e.strb   = NO'(1) << a;
            end else begin
                e.rdata = out_m[a];
            end
        end else if (a < NO + NI) begin
            if (wr) e.err = 1'b1;
`ifdef HDLV_REG_BANK_SNAPSHOT_EN
            else e.rdata = sh_m[a-NO];
`else
            else e.rdata = in_m[a-NO];
`endif
        end
`ifdef HDLV_REG_BANK_SNAPSHOT_EN
        else if (a == (1 << AW) - 1) begin
            if (wr) begin
                for (int i = 0; i < NI; i++) sh_m[i] = in_m[i];
                cnt_m = cnt_m + 1;
            end else begin
                e.rdata = cnt_m;
            end
        end
`endif
        else begin
            e.err = 1'b1;
        end
    endtask

    // One host transaction; hold = extra cycles rsp_ready stays low,
    // poke = present a competing request while the response is pending.
    task automatic access(input bit wr, input int a, input logic [DW-1:0] wd,
                          input int hold, input bit poke);
        exp_t e;
        exp_t got;
        logic [DW-1:0] first_rdata;
        int n;
        model(wr, a, wd, e);
        sb.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = AW'(a);
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            void'(sb.pop_front());
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rsp_not_early", rsp_valid, 0);
        @(posedge clk); #1;
        chk("rsp_latency", rsp_valid, 1);
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) begin
            chk("rsp_timeout", rsp_valid, 1);
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, got.rdata);
        chk("rsp_err", rsp_err, got.err);
        chk("wr_strobe", user_wr_strobe, got.strb);
        first_rdata = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = '0;
                req_wdata = '1;
            end
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, first_rdata);
            chk("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_hs_req_ready", req_ready, 1);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_strobe", user_wr_strobe, 0);
        chk("user_data_out", user_data_out, out_packed());
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        user_data_in = '0;
        for (int i = 0; i < NI; i++) in_m[i] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_data_out", user_data_out, 0);
        chk("rst_strobe", user_wr_strobe, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 2, 32'hDEADBEEF, 0, 1'b0);
        access(1'b0, 2, '0, 0, 1'b0);
        access(1'b1, 0, 32'h1111_1111, 0, 1'b0);
        access(1'b1, 3, 32'hCAFE_F00D, 0, 1'b0);
        access(1'b0, 3, '0, 0, 1'b0);

        set_in(1, 32'h1234_5678);
        set_in(3, 32'h0BAD_F00D);
        repeat (2) @(posedge clk);
        #1;
        access(1'b0, 5, '0, 0, 1'b0);
        access(1'b0, 7, '0, 0, 1'b0);

        access(1'b1, 20, 32'h5A5A_5A5A, 0, 1'b0);
        access(1'b0, 20, '0, 0, 1'b0);
        access(1'b1, 5, 32'h7777_7777, 0, 1'b0);
        access(1'b0, 8, '0, 0, 1'b0);

        access(1'b0, 2, '0, 5, 1'b1);

        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_rsp_ready_valid", rsp_valid, 0);
        chk("idle_rsp_ready_ready", req_ready, 1);
        rsp_ready = 1'b0;

        set_in(0, 32'hA);
        repeat (2) @(posedge clk);
        #1;
        access(1'b1, 31, '0, 0, 1'b0);
        set_in(0, 32'hB);
        repeat (2) @(posedge clk);
        #1;
        access(1'b0, 4, '0, 0, 1'b0);
        access(1'b0, 31, '0, 0, 1'b0);

        // Reset lands on the edge that would end ACCESS.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = '0;
        req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_strobe", user_wr_strobe, 0);
        chk("midrst_data_out", user_data_out, 0);
        @(posedge clk); #1;
        chk("midrst_strobe_after", user_wr_strobe, 0);
        repeat (2) @(posedge clk);
        #1;
        access(1'b0, 0, '0, 0, 1'b0);
        access(1'b0, 5, '0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
